sd_dac_seq: RTL and testbench

//  Multi-channel first-order sigma-delta DAC with a programmable level table
//  and per-channel step sequencer; successor to the single-channel threshold
//  DAC. Each channel emits a 1-bit density stream (code/2^DW) for an external
//  RC filter. Stepping is a synchronised loaddac pulse, no longer a clock.
//  A settle counter flags when the analogue level is usable after a change.

---
 rtl/sd_dac_seq.sv | 165 ++++++++++++++++
 tb/tb_sd_dac_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac_seq.sv
// Multi-channel first-order sigma-delta DAC with a programmable level table and per-channel step sequencer.
// Latency: loaddac edge -> step +2 clk (sync); step -> idx/direct_reg +1 -> code +2 -> DACout +3.
// Backpressure: none; every step request is taken. Steps aimed at a channel >= NCH are dropped.
//
// Ports:
//   Clk        system clock
//   resdac     async reset, active-high; clears all state including the loaddac synchroniser
//   loaddac    step request, asynchronous level; its rising edge produces a single step
//   mode       0 = channels play table[idx], 1 = channels play direct_reg (global to all channels)
//   ch_sel     channel targeted by a step, a direct load, and the lvl_idx readback
//   direct_val code captured into direct_reg[ch_sel] on a step while mode = 1
//   tbl_we     table write strobe; tbl_addr >= NLEV is ignored
//   tbl_addr   table write address
//   tbl_wdata  table write data
//   DACout     registered 1-bit density streams, one per channel
//   lvl_idx    current table index of channel ch_sel (0 when ch_sel is out of range)
//   ready      high once SETTLE cycles have passed with no code change on any channel
//   wrap       single-cycle pulse when a channel index wraps from NLEV-1 back to 1
module sd_dac_seq #(
  parameter int DW     = 8,
  parameter int NCH    = 2,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int NLEV   = 10,
  parameter int IDXW   = 4,
  parameter int SETTLE = 255
) (
  input  logic            Clk,
  input  logic            resdac,
  input  logic            loaddac,
  input  logic            mode,
  input  logic [CHW-1:0]  ch_sel,
  input  logic [DW-1:0]   direct_val,
  input  logic            tbl_we,
  input  logic [IDXW-1:0] tbl_addr,
  input  logic [DW-1:0]   tbl_wdata,
  output logic [NCH-1:0]  DACout,
  output logic [IDXW-1:0] lvl_idx,
  output logic            ready,
  output logic            wrap
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  // Power-up table: index 0 parks at 4*NLEV, the sweep entries climb in steps of 4.
  function automatic logic [DW-1:0] tbl_init(input int k);
    return (k == 0) ? DW'(4 * NLEV) : DW'(4 * k + 4);
  endfunction

  logic            ld_s1, ld_s2, ld_s3;
  logic            step;
  logic            ch_ok;
  logic            tbl_ok;
  logic            code_chg;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   tbl        [NLEV];
  logic [IDXW-1:0] idx        [NCH];
  logic [DW-1:0]   direct_reg [NCH];
  logic [DW-1:0]   code       [NCH];
  logic [DW-1:0]   code_nxt   [NCH];
  logic [DW-1:0]   acc        [NCH];
  logic [DW:0]     sum        [NCH];

  assign step   = ld_s2 & ~ld_s3;
  assign ch_ok  = (32'(ch_sel) < NCH);
  assign tbl_ok = (32'(tbl_addr) < NLEV);
  assign ready  = (cnt == CW'(SETTLE));

  // Two flops bring loaddac into the Clk domain; the third gives the rising-edge detect.
  always_ff @(posedge Clk or posedge resdac) begin
    if (resdac) begin
      ld_s1 <= 1'b0;
      ld_s2 <= 1'b0;
      ld_s3 <= 1'b0;
    end else begin
      ld_s1 <= loaddac;
      ld_s2 <= ld_s1;
      ld_s3 <= ld_s2;
    end
  end

  // Level table. A write landing with a step is seen by the new index on the following refresh.
  always_ff @(posedge Clk or posedge resdac) begin
    if (resdac) begin
      for (int k = 0; k < NLEV; k++) begin
        tbl[k] <= tbl_init(k);
      end
    end else if (tbl_we && tbl_ok) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  // Step sequencer. Index 0 is only reachable through reset; the sweep cycles 1..NLEV-1.
  always_ff @(posedge Clk or posedge resdac) begin
    if (resdac) begin
      wrap <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        idx[c]        <= '0;
        direct_reg[c] <= '0;
      end
    end else begin
      wrap <= 1'b0;
      if (step && ch_ok) begin
        if (!mode) begin
          if (idx[ch_sel] == IDXW'(NLEV - 1)) begin
            idx[ch_sel] <= IDXW'(1);
            wrap        <= 1'b1;
          end else begin
            idx[ch_sel] <= idx[ch_sel] + 1'b1;
          end
        end else begin
          direct_reg[ch_sel] <= direct_val;
        end
      end
    end
  end

  always_comb begin
    code_chg = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      code_nxt[c] = mode ? direct_reg[c] : tbl[idx[c]];
      sum[c]      = {1'b0, acc[c]} + {1'b0, code[c]};
      if (code_nxt[c] != code[c]) begin
        code_chg = 1'b1;
      end
    end
  end

  // Code refresh and modulator: the accumulator carry is the output bit, so over any
  // 2^DW cycles of constant code the stream holds exactly `code` ones.
  always_ff @(posedge Clk or posedge resdac) begin
    if (resdac) begin
      DACout <= '0;
      for (int c = 0; c < NCH; c++) begin
        code[c] <= tbl_init(0);
        acc[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        code[c]   <= code_nxt[c];
        acc[c]    <= sum[c][DW-1:0];
        DACout[c] <= sum[c][DW];
      end
    end
  end

  // Settle timer restarts on the edge where any code register takes a new value.
  always_ff @(posedge Clk or posedge resdac) begin
    if (resdac) begin
      cnt <= '0;
    end else if (code_chg) begin
      cnt <= '0;
    end else if (cnt != CW'(SETTLE)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    lvl_idx = '0;
    if (ch_ok) begin
      lvl_idx = idx[ch_sel];
    end
  end

endmodule

// File: tb/tb_sd_dac_seq.sv
// Self-checking bench for sd_dac_seq: step vectors via a scoreboard queue plus hand-written corner sequences.
// Latency: checks sample 1 ns after the rising edge.
// Backpressure: not applicable.
module tb_sd_dac_seq;
  localparam int DW   = 8;
  localparam int NCH  = 2;
  localparam int CHW  = 1;
  localparam int NLEV = 10;
  localparam int IDXW = 4;

  logic            Clk = 1'b0;
  logic            resdac;
  logic            loaddac;
  logic            mode;
  logic [CHW-1:0]  ch_sel;
  logic [DW-1:0]   direct_val;
  logic            tbl_we;
  logic [IDXW-1:0] tbl_addr;
  logic [DW-1:0]   tbl_wdata;
  logic [NCH-1:0]  DACout;
  logic [IDXW-1:0] lvl_idx;
  logic            ready;
  logic            wrap;

  always #5 Clk = ~Clk;

  sd_dac_seq #(
    .DW(DW), .NCH(NCH), .CHW(CHW), .NLEV(NLEV), .IDXW(IDXW), .SETTLE(255)
  ) dut (
    .Clk(Clk), .resdac(resdac), .loaddac(loaddac), .mode(mode), .ch_sel(ch_sel),
    .direct_val(direct_val), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .DACout(DACout), .lvl_idx(lvl_idx), .ready(ready), .wrap(wrap)
  );

  typedef struct {
    int mode;
    int ch;
    int dval;
    int idx;
    int wrap;
    int d0;
    int d1;
  } vec_t;

  vec_t vecs [14];
  vec_t exp_q [$];
  int   total = 0;
  int   passed = 0;
  int   wrap_cnt = 0;

  always @(negedge Clk) if (wrap) wrap_cnt++;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
  endtask

  task automatic measure(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      n0 += int'(DACout[0]);
      n1 += int'(DACout[1]);
    end
  endtask

  task automatic pulse();
    loaddac = 1'b1;
    repeat (3) tick();
    loaddac = 1'b0;
    repeat (5) tick();
  endtask

  task automatic apply_vec(input int i);
    vec_t e;
    int   w0, n0, n1;
    mode       = (vecs[i].mode != 0);
    ch_sel     = CHW'(vecs[i].ch);
    direct_val = DW'(vecs[i].dval);
    exp_q.push_back(vecs[i]);
    w0 = wrap_cnt;
    pulse();
    measure(n0, n1);
    e = exp_q.pop_front();
    check($sformatf("v%0d lvl_idx", i), int'(lvl_idx), e.idx);
    check($sformatf("v%0d wrap", i), wrap_cnt - w0, e.wrap);
    check($sformatf("v%0d ones0", i), n0, e.d0);
    check($sformatf("v%0d ones1", i), n1, e.d1);
  endtask

  initial begin
    int n0, n1, drops, m, bad;

    resdac = 1'b1; loaddac = 1'b0; mode = 1'b0; ch_sel = '0;
    direct_val = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;

    //            mode ch dval idx wrap d0   d1
    vecs[0]  = '{0, 0, 0,   1, 0,   8,  40};
    vecs[1]  = '{0, 0, 0,   2, 0,   12, 40};
    vecs[2]  = '{0, 0, 0,   3, 0,   16, 40};
    vecs[3]  = '{0, 0, 0,   4, 0,   20, 40};
    vecs[4]  = '{0, 0, 0,   5, 0,   24, 40};
    vecs[5]  = '{0, 0, 0,   6, 0,   28, 40};
    vecs[6]  = '{0, 0, 0,   7, 0,   32, 40};
    vecs[7]  = '{0, 0, 0,   8, 0,   36, 40};
    vecs[8]  = '{0, 0, 0,   9, 0,   40, 40};
    vecs[9]  = '{0, 0, 0,   1, 1,   8,  40};
    vecs[10] = '{1, 1, 200, 0, 0,   0,  200};
    vecs[11] = '{0, 0, 0,   2, 0,   12, 40};
    vecs[12] = '{0, 0, 0,   3, 0,   16, 40};
    vecs[13] = '{0, 1, 0,   1, 0,   16, 8};

    // T1: reset state, settle timing and park density
    repeat (3) tick();
    check("rst DACout", int'(DACout), 0);
    check("rst lvl_idx", int'(lvl_idx), 0);
    check("rst ready", int'(ready), 0);
    check("rst wrap", int'(wrap), 0);
    resdac = 1'b0;
    repeat (254) tick();
    check("t1 ready before 255", int'(ready), 0);
    tick();
    check("t1 ready at 255", int'(ready), 1);
    measure(n0, n1);
    check("t1 ones0", n0, 40);
    check("t1 ones1", n1, 40);

    // T2 sweep with wrap, T3 direct load
    for (int i = 0; i <= 10; i++) apply_vec(i);

    // Settle restart after a direct code change, then a same-code step that must keep ready
    ch_sel = 1'b1; direct_val = 8'd100; loaddac = 1'b1;
    for (int k = 1; k <= 259; k++) begin
      tick();
      if (k == 3) loaddac = 1'b0;
      if (k == 258) check("t3 ready low", int'(ready), 0);
    end
    check("t3 ready high", int'(ready), 1);
    drops = 0;
    loaddac = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) loaddac = 1'b0;
      if (!ready) drops++;
    end
    check("t3 same code drops", drops, 0);
    measure(n0, n1);
    check("t3 ones0", n0, 0);
    check("t3 ones1", n1, 100);

    for (int i = 11; i <= 13; i++) apply_vec(i);

    // T4: live table write to the entry in use, then out-of-range writes
    ch_sel = 1'b0; mode = 1'b0;
    check("t4 idx", int'(lvl_idx), 3);
    tbl_we = 1'b1; tbl_addr = 4'd3; tbl_wdata = 8'd0;
    tick();
    tbl_we = 1'b0;
    repeat (2) tick();
    check("t4 out at write+2", int'(DACout[0]), 0);
    measure(n0, n1);
    check("t4 ones0", n0, 0);
    tbl_we = 1'b1; tbl_addr = 4'd12; tbl_wdata = 8'hFF;
    tick();
    tbl_addr = 4'd10;
    tick();
    tbl_we = 1'b0;
    repeat (4) tick();
    measure(n0, n1);
    check("t4 oor ones0", n0, 0);
    check("t4 oor ones1", n1, 8);

    // T6: table write in the step cycle, sub-cycle glitch, 2-clk and long pulses
    loaddac = 1'b1;
    repeat (2) tick();
    tbl_we = 1'b1; tbl_addr = 4'd4; tbl_wdata = 8'd100;
    tick();
    tbl_we = 1'b0; loaddac = 1'b0;
    repeat (5) tick();
    measure(n0, n1);
    check("t6 same-cycle idx", int'(lvl_idx), 4);
    check("t6 same-cycle ones0", n0, 100);
    loaddac = 1'b1;
    #2;
    loaddac = 1'b0;
    repeat (10) tick();
    check("t6 glitch idx", int'(lvl_idx), 4);
    loaddac = 1'b1;
    repeat (2) tick();
    loaddac = 1'b0;
    repeat (6) tick();
    check("t6 2clk idx", int'(lvl_idx), 5);
    measure(n0, n1);
    check("t6 2clk ones0", n0, 24);
    loaddac = 1'b1;
    repeat (20) tick();
    loaddac = 1'b0;
    repeat (6) tick();
    check("t6 long idx", int'(lvl_idx), 6);

    // T5: reset mid-stream with loaddac held high across it
    resdac = 1'b1; loaddac = 1'b1;
    tick();
    check("t5 rst idx", int'(lvl_idx), 0);
    check("t5 rst DACout", int'(DACout), 0);
    check("t5 rst ready", int'(ready), 0);
    resdac = 1'b0;
    m = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      m += 40;
      if (int'(DACout[1]) != ((m >= 256) ? 1 : 0)) bad++;
      m = m % 256;
    end
    check("t5 stream from acc 0", bad, 0);
    loaddac = 1'b0;
    repeat (6) tick();
    check("t5 single step idx", int'(lvl_idx), 1);
    measure(n0, n1);
    check("t5 ones0", n0, 8);
    check("t5 ones1", n1, 40);
    pulse();
    pulse();
    measure(n0, n1);
    check("t5 table restored idx", int'(lvl_idx), 3);
    check("t5 table restored ones0", n0, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
